// File: rtl/pc_unit.sv
// Purpose : fetch-stage program counter with prioritised redirects, alignment check and halt/resume.
// Latency : every PC change appears on ADDRESS_OUT one cycle after the deciding edge; flush/misaligned are registered pulses.
// Backpressure: sequential advance only when fetch_valid && fetch_ready && !stall; redirects ignore backpressure.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   fetch_ready, stall    - fetch handshake / hazard hold for sequential advance
//   trap_req/trap_vector  - trap entry (vector forced aligned), honoured in RUN and HALTED
//   mret_req/mret_target  - return from trap, alignment checked
//   branch_taken/_target  - branch/jump redirect, alignment checked
//   halt_req, resume_req  - debug freeze / release
//   ADDRESS_OUT, pc_plus_step, fetch_valid, flush, misaligned, bad_addr, halted - status/outputs
module pc_unit #(
  parameter int                   BIT_WIDTH    = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   STEP         = 4,
  parameter int                   ALIGN_BITS   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_ready,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [BIT_WIDTH-1:0] branch_target,
  input  logic                 trap_req,
  input  logic [BIT_WIDTH-1:0] trap_vector,
  input  logic                 mret_req,
  input  logic [BIT_WIDTH-1:0] mret_target,
  input  logic                 halt_req,
  input  logic                 resume_req,
  output logic [BIT_WIDTH-1:0] ADDRESS_OUT,
  output logic [BIT_WIDTH-1:0] pc_plus_step,
  output logic                 fetch_valid,
  output logic                 flush,
  output logic                 misaligned,
  output logic [BIT_WIDTH-1:0] bad_addr,
  output logic                 halted
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Low address bits that must be zero in a legal redirect target.
  localparam logic [BIT_WIDTH-1:0] ALIGN_MASK = BIT_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [1:0]           state_q, state_d;
  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic                 flush_q, flush_d;
  logic                 mis_q, mis_d;
  logic [BIT_WIDTH-1:0] bad_addr_q, bad_addr_d;

  logic [BIT_WIDTH-1:0] trap_aligned;
  logic                 mret_bad;
  logic                 branch_bad;

  assign trap_aligned = trap_vector & ~ALIGN_MASK;
  assign mret_bad     = (mret_target & ALIGN_MASK) != '0;
  assign branch_bad   = (branch_target & ALIGN_MASK) != '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;
    bad_addr_d = bad_addr_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // One action per cycle; a rejected redirect still consumes the cycle.
        if (trap_req) begin
          pc_d    = trap_aligned;
          flush_d = 1'b1;
        end else if (mret_req) begin
          if (mret_bad) begin
            mis_d      = 1'b1;
            bad_addr_d = mret_target;
          end else begin
            pc_d    = mret_target;
            flush_d = 1'b1;
          end
        end else if (branch_taken) begin
          if (branch_bad) begin
            mis_d      = 1'b1;
            bad_addr_d = branch_target;
          end else begin
            pc_d    = branch_target;
            flush_d = 1'b1;
          end
        end else if (halt_req) begin
          state_d = ST_HALTED;
        end else if (fetch_ready && !stall) begin
          pc_d = pc_plus_step;
        end
      end
      ST_HALTED: begin
        // Traps still land while frozen so the handler address is ready on resume.
        if (trap_req) begin
          pc_d    = trap_aligned;
          flush_d = 1'b1;
        end
        if (resume_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign ADDRESS_OUT  = pc_q;
  assign pc_plus_step = pc_q + BIT_WIDTH'(STEP);  // wraps silently
  assign fetch_valid  = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALTED);
  assign flush        = flush_q;
  assign misaligned   = mis_q;
  assign bad_addr     = bad_addr_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the HELIORV32 fetch stage. It holds the current fetch address and advances it sequentially under a valid/ready fetch handshake. It accepts prioritised redirects: trap entry, trap return, and branch/jump. It checks target alignment and supports a debug-style halt/resume state machine. It drives the instruction-memory address and the pipeline flush.

Parameters:
BIT_WIDTH, 32, address width in bits (at least 8).
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
STEP, 4, sequential increment in bytes.
ALIGN_BITS, 2, number of low address bits that must be zero in a legal target (1 when compressed instructions are enabled).

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
fetch_ready  in  1  instruction memory accepts ADDRESS_OUT this cycle
stall  in  1  pipeline hazard; blocks sequential advance
branch_taken  in  1  branch/jump redirect request
branch_target  in  BIT_WIDTH  branch/jump destination
trap_req  in  1  trap entry request
trap_vector  in  BIT_WIDTH  trap handler address (mtvec)
mret_req  in  1  return-from-trap request
mret_target  in  BIT_WIDTH  return address (mepc)
halt_req  in  1  request to freeze fetch
resume_req  in  1  request to leave HALTED
ADDRESS_OUT  out  BIT_WIDTH  current PC / fetch address
pc_plus_step  out  BIT_WIDTH  ADDRESS_OUT + STEP (combinational, modulo 2^BIT_WIDTH)
fetch_valid  out  1  ADDRESS_OUT is a valid fetch request
flush  out  1  one-cycle pulse after any accepted redirect
misaligned  out  1  one-cycle pulse when a redirect target was illegal
bad_addr  out  BIT_WIDTH  last rejected target (sticky until the next rejection or reset)
halted  out  1  high while in HALTED

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: ADDRESS_OUT=RESET_VECTOR, state=BOOT, fetch_valid=0, flush=0, misaligned=0, bad_addr=0, halted=0.
- Reset asserted in any state, including mid-redirect or HALTED, overrides all other inputs in that cycle.
- States:
  - BOOT: lasts exactly one cycle, then goes to RUN.
  - RUN: fetch_valid=1.
  - HALTED: fetch_valid=0, halted=1.
- RUN update priority, highest first; one action per cycle:
  1. trap_req: PC <= trap_vector; flush=1.
  2. mret_req: PC <= mret_target; flush=1.
  3. branch_taken: PC <= branch_target; flush=1.
  4. halt_req: go to HALTED; PC holds.
  5. fetch_valid && fetch_ready && !stall: PC <= PC + STEP.
  6. Otherwise: PC holds.
- Redirects:
  - Taken regardless of stall or fetch_ready.
  - Lower-priority redirect requests in the same cycle are dropped.
- Alignment check:
  - Applies to mret and branch targets only. trap_vector is forced aligned by clearing its low ALIGN_BITS bits.
  - A target with any nonzero bit in [ALIGN_BITS-1:0] is rejected.
  - On rejection: PC holds, misaligned=1 for the next cycle, bad_addr <= target, flush=0.
  - A rejected redirect does not fall through to lower-priority actions in that cycle.
- HALTED:
  - PC holds.
  - trap_req is still honoured: PC <= trap_vector, flush=1, state stays HALTED.
  - Other redirects are ignored.
  - resume_req goes to RUN the next cycle.
  - halt_req and resume_req together: resume wins.
- BOOT ignores every request except reset.
- flush and misaligned are registered, so they appear in the cycle after the event and last one cycle.
- Sequential advance wraps modulo 2^BIT_WIDTH: 32'hFFFF_FFFC + 4 gives 0. The wrap is not flagged.
- Latency: every PC change becomes visible on ADDRESS_OUT one cycle after the deciding edge. There is no combinational path from inputs to ADDRESS_OUT.

Test Plan:
- Reset, then fetch_ready=1 for 4 cycles → ADDRESS_OUT 0 (BOOT), 0, 4, 8, 12; fetch_valid rises in cycle 2.
- In RUN at PC=0x10: stall=1 for 2 cycles, then fetch_ready=0 for 1 cycle → PC holds at 0x10 for 3 cycles, then 0x14.
- Same cycle trap_req (trap_vector=0x103), branch_taken (target 0x40) and mret_req → PC=0x100, flush pulses once, branch and mret dropped.
- branch_target=0x42 with ALIGN_BITS=2 → PC holds, misaligned pulses 1 cycle, bad_addr=0x42; repeat with ALIGN_BITS=1 → PC=0x42 accepted.
- At PC=0xFFFF_FFFC, fetch accepted → PC=0x0000_0000, no flag.
- halt_req at PC=0x20 → halted=1, PC frozen 5 cycles, branch ignored; trap_req in HALTED → PC=trap_vector, still halted; resume_req → RUN, fetch_valid=1; reset asserted mid-HALTED → PC=RESET_VECTOR, BOOT.
